// File: rtl/vector_mem_responder_if.sv
// vector_mem_responder_if: vector request, scalar memory and completion bus (optional VECTOR_MEM_RESP_MASK_EN adds req_mask_i)
interface vector_mem_responder_if #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 64,
  parameter int ADDR_W = 64
);
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic                          req_is_store_i;
  logic [LANES-1:0][ADDR_W-1:0]  req_addr_i;
  logic [LANES*ELEM_W-1:0]       req_wdata_i;
`ifdef VECTOR_MEM_RESP_MASK_EN
  logic [LANES-1:0]              req_mask_i;
`endif
  logic                          mem_req_valid_o;
  logic                          mem_req_ready_i;
  logic                          mem_we_o;
  logic [ADDR_W-1:0]             mem_addr_o;
  logic [ELEM_W-1:0]             mem_wdata_o;
  logic                          mem_rvalid_i;
  logic [ELEM_W-1:0]             mem_rdata_i;
  logic                          result_valid_o;
  logic                          result_ready_i;
  logic                          result_is_store_o;
  logic [LANES*ELEM_W-1:0]       result_data_o;
  modport slave (
`ifdef VECTOR_MEM_RESP_MASK_EN
    input  req_mask_i,
`endif
    input  req_valid_i, req_is_store_i, req_addr_i, req_wdata_i,
    input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i, result_ready_i,
    output req_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output result_valid_o, result_is_store_o, result_data_o
  );
  modport master (
`ifdef VECTOR_MEM_RESP_MASK_EN
    output req_mask_i,
`endif
    output req_valid_i, req_is_store_i, req_addr_i, req_wdata_i,
    output mem_req_ready_i, mem_rvalid_i, mem_rdata_i, result_ready_i,
    input  req_ready_o, mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  result_valid_o, result_is_store_o, result_data_o
  );
endinterface

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: serializes a vector load/store onto one scalar memory port (optional VECTOR_MEM_RESP_MASK_EN lane mask)
module vector_mem_responder #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 64,
  parameter int ADDR_W = 64
) (
  input logic clk,
  input logic rst,
  vector_mem_responder_if.slave bus
);
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e                       state_q, state_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [LANES-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0][ELEM_W-1:0] wdata_q, wdata_d, data_q, data_d;
  logic                         st_q, st_d;
  logic                         active, last, issue;
`ifdef VECTOR_MEM_RESP_MASK_EN
  logic [LANES-1:0]             mask_q, mask_d;
  assign active = mask_q[lane_q];
`else
  assign active = 1'b1;
`endif
  assign last  = lane_q == LW'(LANES-1);
  assign issue = state_q == ISSUE && active;
  assign bus.req_ready_o       = state_q == IDLE;
  assign bus.mem_req_valid_o   = issue;
  assign bus.mem_we_o          = issue && st_q;
  assign bus.mem_addr_o        = issue ? addr_q[lane_q] : '0;
  assign bus.mem_wdata_o       = issue && st_q ? wdata_q[lane_q] : '0;
  assign bus.result_valid_o    = state_q == RESP;
  assign bus.result_is_store_o = state_q == RESP && st_q;
  assign bus.result_data_o     = data_q;
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    st_d    = st_q;
    data_d  = data_q;
`ifdef VECTOR_MEM_RESP_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        addr_d  = bus.req_addr_i;
        wdata_d = bus.req_wdata_i;
        st_d    = bus.req_is_store_i;
`ifdef VECTOR_MEM_RESP_MASK_EN
        mask_d  = bus.req_mask_i;
`endif
        data_d  = '0;
        lane_d  = '0;
        state_d = ISSUE;
      end
      // masked lanes and store handshakes advance in place; loads wait for their return
      ISSUE: if (!active || (bus.mem_req_ready_i && st_q)) begin
        lane_d  = lane_q + 1'b1;
        state_d = last ? RESP : ISSUE;
      end else if (bus.mem_req_ready_i) begin
        state_d = WAIT;
      end
      WAIT: if (bus.mem_rvalid_i) begin
        data_d[lane_q] = bus.mem_rdata_i;
        lane_d         = lane_q + 1'b1;
        state_d        = last ? RESP : ISSUE;
      end
      RESP: if (bus.result_ready_i) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      st_q    <= 1'b0;
      data_q  <= '0;
`ifdef VECTOR_MEM_RESP_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      st_q    <= st_d;
      data_q  <= data_d;
`ifdef VECTOR_MEM_RESP_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end
endmodule

// File: tb/tb_vector_mem_responder.sv
// tb_vector_mem_responder: directed checks of load, store, stall, completion hold and mid-flight reset
module tb_vector_mem_responder;
  localparam int L = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  vector_mem_responder_if bus ();
  vector_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_data(input logic st, input logic [L-1:0] m);
    logic [L-1:0][63:0] d;
    for (int i = 0; i < L; i++) d[i] = (!st && m[i]) ? 64'hA0 + 64'(i) : 64'h0;
    return d;
  endfunction

  task automatic check_reset(input string t);
    check({t, "_req_ready"}, bus.req_ready_o, 1);
    check({t, "_mem_valid"}, bus.mem_req_valid_o, 0);
    check({t, "_mem_we"}, bus.mem_we_o, 0);
    check({t, "_mem_addr"}, bus.mem_addr_o, 0);
    check({t, "_mem_wdata"}, bus.mem_wdata_o, 0);
    check({t, "_res_valid"}, bus.result_valid_o, 0);
    check({t, "_res_store"}, bus.result_is_store_o, 0);
    check({t, "_res_data"}, bus.result_data_o, 0);
  endtask

  task automatic set_req(input logic st, input logic [L-1:0] m);
    for (int i = 0; i < L; i++) begin
      bus.req_addr_i[i] = 64'h1000 + 64'(8 * i);
      bus.req_wdata_i[i*64 +: 64] = 64'h11 * 64'(i + 1);
    end
    bus.req_is_store_i = st;
`ifdef VECTOR_MEM_RESP_MASK_EN
    bus.req_mask_i = m;
`else
    if (m != '1) $display("mask ignored in this build");
`endif
  endtask

  task automatic request(input logic st, input logic [L-1:0] m);
    set_req(st, m);
    bus.req_valid_i = 1'b1;
    check("accept_ready", bus.req_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  // Cycle-by-cycle memory model; starts on the negedge after the accept edge
  task automatic run(input logic st, input logic [L-1:0] m, input int stall_lane,
                     input int abort_at, input int exp_cyc);
    int el = 0;
    int stall = 3;
    int cyc = 0;
    logic pend = 1'b0;
    logic [63:0] rdv = 64'h0;
    while (cyc < 200) begin
      bus.mem_rvalid_i = pend;
      bus.mem_rdata_i  = pend ? rdv : 64'h0;
      pend = 1'b0;
      while (el < L && !m[el]) el++;
      bus.mem_req_ready_i = !(el == stall_lane && stall > 0);
      #1;
      if (bus.result_valid_o) break;
      if (bus.mem_req_valid_o && !bus.mem_req_ready_i) begin
        stall--;
        check("stall_addr", bus.mem_addr_o, 64'h1000 + 64'(8 * el));
      end else if (bus.mem_req_valid_o) begin
        check("mem_addr", bus.mem_addr_o, 64'h1000 + 64'(8 * el));
        check("mem_we", bus.mem_we_o, st);
        check("mem_wdata", bus.mem_wdata_o, st ? 64'h11 * 64'(el + 1) : 64'h0);
        if (!st) begin
          pend = 1'b1;
          rdv  = 64'hA0 + ((bus.mem_addr_o - 64'h1000) >> 3);
        end
        el++;
        if (el == abort_at) begin
          @(posedge clk);
          @(negedge clk);
          bus.mem_rvalid_i = 1'b0;
          return;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.mem_rvalid_i = 1'b0;
    check("latency", cyc, exp_cyc);
    check("lanes_done", el, L);
    check("res_valid", bus.result_valid_o, 1);
    check("res_store", bus.result_is_store_o, st);
    check("res_data", bus.result_data_o, exp_data(st, m));
  endtask

  task automatic finish_resp();
    bus.result_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    check("back_idle", bus.req_ready_o, 1);
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.result_ready_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 64'h0;
    set_req(1'b0, '1);
    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    request(1'b0, '1);
    run(1'b0, '1, -1, -1, 16);
    finish_resp();
    request(1'b1, '1);
    run(1'b1, '1, -1, -1, 8);
    finish_resp();
    request(1'b0, '1);
    run(1'b0, '1, 2, -1, 19);
    // Completion held while a new request waits
    set_req(1'b1, '1);
    bus.req_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", bus.result_valid_o, 1);
      check("hold_ready", bus.req_ready_o, 0);
      check("hold_data", bus.result_data_o, exp_data(1'b0, '1));
      check("hold_nomem", bus.mem_req_valid_o, 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.result_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    check("exit_valid", bus.result_valid_o, 0);
    check("exit_ready", bus.req_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    run(1'b1, '1, -1, -1, 8);
    finish_resp();
    // Reset while waiting on lane 4, followed by a stray return
    request(1'b0, '1);
    run(1'b0, '1, -1, 5, 0);
    #1;
    check("wait_nomem", bus.mem_req_valid_o, 0);
    check("wait_ready", bus.req_ready_o, 0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 64'h0;
    check_reset("stray");
    request(1'b0, '1);
    run(1'b0, '1, -1, -1, 16);
    finish_resp();
`ifdef VECTOR_MEM_RESP_MASK_EN
    request(1'b0, 8'b1010_0101);
    run(1'b0, 8'b1010_0101, -1, -1, 12);
    finish_resp();
    request(1'b0, 8'b0000_0000);
    run(1'b0, 8'b0000_0000, -1, -1, 8);
    finish_resp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the 8-lane vector load/store request bus.
- Accepts one whole vector request: per-lane addresses plus 512-bit write data. Serializes the lanes onto a single 64-bit scalar memory port, gathers load returns, and presents one assembled 512-bit result.
- Sits between the vector LSU request outputs and the L1 data-cache port.

Parameters:
- LANES, 8, number of vector lanes per request; a power of two, minimum 2.
- ELEM_W, 64, lane element width in bits; also the memory port data width.
- ADDR_W, 64, address width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- req_valid_i  input  1  vector request valid
- req_ready_o  output  1  responder can accept a request
- req_is_store_i  input  1  1 = scatter/store, 0 = gather/load
- req_addr_i  input  LANES x ADDR_W  per-lane byte addresses, packed [LANES-1:0][ADDR_W-1:0]
- req_wdata_i  input  LANES*ELEM_W  store data; lane i is bits [i*ELEM_W +: ELEM_W]
- mem_req_valid_o  output  1  scalar memory request valid
- mem_req_ready_i  input  1  memory accepts the request
- mem_we_o  output  1  scalar write enable
- mem_addr_o  output  ADDR_W  scalar address
- mem_wdata_o  output  ELEM_W  scalar write data
- mem_rvalid_i  input  1  load return valid
- mem_rdata_i  input  ELEM_W  load return data
- result_valid_o  output  1  vector completion valid
- result_ready_i  input  1  consumer accepts completion
- result_is_store_o  output  1  completion belongs to a store
- result_data_o  output  LANES*ELEM_W  gathered load data; all zero for stores

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Lane counter has clog2(LANES) bits.
- Reset (async, any state): state=IDLE; lane counter=0; result data register=0.
  - Output reset values: req_ready_o=1, mem_req_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, result_valid_o=0, result_is_store_o=0, result_data_o=0.
  - Reset mid-operation discards the in-flight vector. A memory return that arrives after reset is ignored.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: latch addr, wdata and is_store; clear the result data register; lane=0; go to ISSUE.
- ISSUE:
  - mem_req_valid_o=1, mem_addr_o=addr[lane], mem_we_o=is_store, mem_wdata_o=wdata lane slice (0 for loads).
  - Outputs stay stable until mem_req_ready_i.
  - On handshake, load: go to WAIT.
  - On handshake, store: if lane==LANES-1 go to RESP; otherwise lane+1 and stay in ISSUE.
- WAIT:
  - mem_req_valid_o=0.
  - On mem_rvalid_i: write mem_rdata_i into the result slice for the current lane. If lane==LANES-1 go to RESP; otherwise lane+1 and go to ISSUE.
  - At most one scalar access is outstanding at a time.
- mem_rvalid_i in any state other than WAIT is ignored.
- RESP:
  - result_valid_o=1; data and is_store are held stable until result_ready_i.
  - On handshake, go to IDLE.
  - req_ready_o=0 in every state except IDLE, so there is no same-cycle accept on RESP exit.
- Latency:
  - Stores with mem_req_ready_i tied 1: LANES ISSUE cycles; result_valid_o rises the cycle after the last lane handshake.
  - Loads with 1-cycle memory return: 2*LANES cycles from accept to result_valid_o.
- Addresses pass through unmodified: no alignment check, no coalescing. Lanes are always issued in ascending order, 0..LANES-1.

Optional Feature:
- Macro: VECTOR_MEM_RESP_MASK_EN.
- Defined:
  - Adds input req_mask_i (width LANES), latched with the request.
  - Masked-off lanes generate no memory access; their result slice is 0.
  - The lane counter advances past masked lanes by one lane per cycle, without entering WAIT.
  - An all-zero mask goes ISSUE->RESP in LANES cycles with zero memory traffic.
- Undefined: port absent; all lanes are accessed.

Test Plan:
- Load, addr[i]=0x1000+8*i, memory returns 0xA0+i one cycle after each handshake -> 8 scalar reads in order 0x1000..0x1038; result_data_o lane i=0xA0+i; result_valid_o 16 cycles after accept.
- Store, wdata lane i=0x11*(i+1), mem_req_ready_i=1 -> 8 writes with mem_we_o=1 and matching data; result_valid_o=1, result_is_store_o=1, result_data_o=0, 8 cycles after accept.
- Load with mem_req_ready_i low 3 cycles on lane 2 -> mem_addr_o stable during the stall; final data still correct.
- result_ready_i low 5 cycles in RESP, with req_valid_i=1 -> result held stable, req_ready_o=0; a new request is accepted only after return to IDLE.
- rst asserted during WAIT on lane 4, then a stray mem_rvalid_i -> all outputs at reset values; next request starts at lane 0 with result data cleared.
- With VECTOR_MEM_RESP_MASK_EN, mask=8'b1010_0101 load -> only lanes 0,2,5,7 accessed; lanes 1,3,4,6 of result are 0.
